hdmi_video_sequencer: RTL and testbench

- Parametrised HDMI-mode successor to the DVI TMDS front end.
- Accepts one pixel per clock (RGB888, hsync, vsync, vde) and emits three 10-bit TMDS words per clock for the 10:1 serializers.
- In HDMI mode it inserts the video preamble and leading video guard band before every active line; in DVI mode it is a fixed-latency encoder only.
- Pipelined (two-stage encode) so it closes timing at 74.25 MHz and above.

---
 rtl/hdmi_tmds_pkg.sv | 21 ++
 rtl/tmds_chan_encoder.sv | 68 ++++++
 rtl/hdmi_video_sequencer.sv | 112 +++++++++++
 tb/tb_hdmi_video_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hdmi_tmds_pkg.sv
// hdmi_tmds_pkg: shared TMDS control tokens, video guard words and sequencer types
package hdmi_tmds_pkg;
  localparam logic [9:0] CTL_TOK [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  localparam logic [9:0] GB_VID_CH0 = 10'b1011001100;
  localparam logic [9:0] GB_VID_CH1 = 10'b0100110011;
  localparam logic [9:0] GB_VID_CH2 = 10'b1011001100;
  typedef enum logic [1:0] {S_CTRL, S_PRE, S_GUARD, S_VIDEO} seq_state_t;
  typedef enum logic [1:0] {M_CTRL, M_GUARD, M_DATA} chan_mode_t;
  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       hsync;
    logic       vsync;
    logic       vde;
  } pix_t;
  function automatic logic [3:0] ones8(input logic [7:0] v);
    ones8 = '0;
    for (int i = 0; i < 8; i++) ones8 = ones8 + {3'b0, v[i]};
  endfunction
endpackage

// File: rtl/tmds_chan_encoder.sv
// tmds_chan_encoder: two-stage TMDS channel encoder (q_m stage, then DC-balance stage)
// TMDS_DISP_MON_EN exposes the running disparity as disp
module tmds_chan_encoder
  import hdmi_tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  input  chan_mode_t mode,
  input  logic [9:0] guard,
  output logic [9:0] q_out
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [4:0] disp
`endif
);
  logic [3:0] n1d, n1q;
  logic [8:0] qm_d, qm;
  logic xn, bal, inv;
  chan_mode_t mode_q;
  logic [1:0] c_q;
  logic [9:0] guard_q;
  logic [4:0] cnt, diff, cnt_nxt;
  always_comb begin
    n1d = ones8(din);
    xn = n1d > 4'd4 || (n1d == 4'd4 && !din[0]);
    qm_d = '0;
    qm_d[0] = din[0];
    for (int i = 1; i < 8; i++) qm_d[i] = qm_d[i-1] ^ din[i] ^ xn;
    qm_d[8] = !xn;
  end
  always_ff @(posedge clk)
    if (rst) begin
      qm <= '0;
      n1q <= '0;
      mode_q <= M_CTRL;
      c_q <= '0;
      guard_q <= '0;
    end else begin
      qm <= qm_d;
      n1q <= ones8(qm_d[7:0]);
      mode_q <= mode;
      c_q <= {c1, c0};
      guard_q <= guard;
    end
  // disparity held as two's complement; diff = n1 - n0 of q_m[7:0]
  always_comb begin
    diff = {n1q, 1'b0} - 5'd8;
    bal = cnt == '0 || diff == '0;
    inv = bal ? !qm[8] : cnt[4] == diff[4];
    cnt_nxt = bal ? (inv ? cnt - diff : cnt + diff)
            : inv ? cnt + {3'b0, qm[8], 1'b0} - diff : cnt - {3'b0, !qm[8], 1'b0} + diff;
  end
  always_ff @(posedge clk)
    if (rst) begin
      q_out <= CTL_TOK[0];
      cnt <= '0;
    end else begin
      q_out <= mode_q == M_DATA ? {inv, qm[8], qm[7:0] ^ {8{inv}}}
             : mode_q == M_GUARD ? guard_q : CTL_TOK[c_q];
      cnt <= mode_q == M_DATA ? cnt_nxt : '0;
    end
`ifdef TMDS_DISP_MON_EN
  assign disp = cnt;
`endif
endmodule

// File: rtl/hdmi_video_sequencer.sv
// hdmi_video_sequencer: HDMI preamble/guard-band inserter feeding three TMDS encoders
// TMDS_DISP_MON_EN builds the sticky running-disparity monitor behind disp_err
module hdmi_video_sequencer
  import hdmi_tmds_pkg::*;
#(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int DISP_LIMIT   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hdmi_mode,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       vde,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2,
  output logic       short_blank_err,
  output logic       disp_err
);
  localparam int LEAD = PREAMBLE_LEN + GUARD_LEN;
  localparam logic [9:0] GB [3] = '{GB_VID_CH0, GB_VID_CH1, GB_VID_CH2};
  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15 || GUARD_LEN < 1 || GUARD_LEN > 3 || DISP_LIMIT < 1) begin : g_param_chk
    $error("hdmi_video_sequencer: parameter out of range");
  end
  pix_t dl [LEAD];
  pix_t d;
  logic vde_q, rise, long_blank, sched, pre, grd;
  logic [4:0] blank_run, cnt, cur_cnt, cnt_dec;
  seq_state_t st, cur_st, st_nxt;
  chan_mode_t mode;
  logic [7:0] din [3];
  logic [1:0] ctl [3];
  logic [9:0] q [3];
  assign d = dl[LEAD-1];
  assign rise = vde && !vde_q;
  assign long_blank = blank_run >= 5'(LEAD);
  assign sched = rise && hdmi_mode && long_blank;
  assign short_blank_err = !rst && rise && hdmi_mode && !long_blank;
  always_ff @(posedge clk)
    if (rst) begin
      vde_q <= 1'b0;
      blank_run <= '0;
      for (int i = 0; i < LEAD; i++) dl[i] <= '0;
    end else begin
      vde_q <= vde;
      blank_run <= vde ? '0 : long_blank ? blank_run : blank_run + 5'd1;
      dl[0] <= '{red, green, blue, hsync, vsync, vde};
      for (int i = 1; i < LEAD; i++) dl[i] <= dl[i-1];
    end
  // a scheduled edge turns the oldest of the LEAD blank slots now leaving the delay line into preamble
  always_comb begin
    cur_st = sched ? S_PRE : st;
    cur_cnt = sched ? 5'(LEAD) : cnt;
    cnt_dec = cur_cnt - 5'd1;
    pre = cur_st == S_PRE;
    grd = cur_st == S_GUARD;
    mode = grd ? M_GUARD : !pre && d.vde ? M_DATA : M_CTRL;
    st_nxt = pre || grd ? (cnt_dec == '0 ? S_VIDEO : cnt_dec <= 5'(GUARD_LEN) ? S_GUARD : S_PRE)
           : d.vde ? S_VIDEO : S_CTRL;
    din[0] = d.blue;
    din[1] = d.green;
    din[2] = d.red;
    ctl[0] = {d.vsync, d.hsync};
    ctl[1] = {1'b0, pre};
    ctl[2] = 2'b00;
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= S_CTRL;
      cnt <= '0;
    end else begin
      st <= st_nxt;
      cnt <= pre || grd ? cnt_dec : '0;
    end
`ifdef TMDS_DISP_MON_EN
  logic [4:0] disp [3];
  logic over;
  always_comb begin
    over = 1'b0;
    for (int i = 0; i < 3; i++) over = over || int'($signed(disp[i])) > DISP_LIMIT || int'($signed(disp[i])) < -DISP_LIMIT;
  end
  always_ff @(posedge clk)
    if (rst) disp_err <= 1'b0;
    else if (over) disp_err <= 1'b1;
`else
  assign disp_err = 1'b0;
`endif
  for (genvar i = 0; i < 3; i++) begin : g_ch
    tmds_chan_encoder u_enc (
      .clk(clk),
      .rst(rst),
      .din(din[i]),
      .c0(ctl[i][0]),
      .c1(ctl[i][1]),
      .mode(mode),
      .guard(GB[i]),
      .q_out(q[i])
`ifdef TMDS_DISP_MON_EN
      ,
      .disp(disp[i])
`endif
    );
  end
  assign tmds_ch0 = q[0];
  assign tmds_ch1 = q[1];
  assign tmds_ch2 = q[2];
endmodule

// File: tb/tb_hdmi_video_sequencer.sv
// tb_hdmi_video_sequencer: directed checks of latency, insertion, short blank, reset and mode changes
module tb_hdmi_video_sequencer;
  localparam logic [9:0] CTL0 = 10'b1101010100;
  localparam logic [9:0] CTL1 = 10'b0010101011;
  localparam logic [9:0] GB0  = 10'b1011001100;
  localparam logic [9:0] GB1  = 10'b0100110011;
  localparam logic [9:0] WA   = 10'b0100000000;
  localparam logic [9:0] WB   = 10'b1111111111;
  localparam logic [9:0] WC   = 10'b0011111111;
  localparam logic [9:0] WD   = 10'b1000000000;
  logic clk = 1'b0, rst = 1'b1, hdmi_mode = 1'b0;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic hsync = 1'b0, vsync = 1'b0, vde = 1'b0;
  logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;
  logic short_blank_err, disp_err;
  logic [9:0] o0 [700], o1 [700], o2 [700];
  logic sb [700];
  int checks = 0, errors = 0;
  hdmi_video_sequencer dut (
    .clk(clk), .rst(rst), .hdmi_mode(hdmi_mode),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .vde(vde),
    .tmds_ch0(tmds_ch0), .tmds_ch1(tmds_ch1), .tmds_ch2(tmds_ch2),
    .short_blank_err(short_blank_err), .disp_err(disp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got[9:0], exp[9:0]);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic blank(input int n, input logic m);
    vde = 1'b0;
    red = '0;
    hdmi_mode = m;
    repeat (n) step();
  endtask
  // hand-derived DVI words: zero channels cycle A/B over 9 pixels; red 0xFF/0x00 settles into A,C,B,D
  function automatic logic [9:0] dword(input int pat, input int ch, input int i);
    if (pat == 1 && ch == 2) begin
      if (i < 9) return (i % 2 == 1) ? WB : WD;
      case ((i - 9) % 4)
        0: return WA;
        1: return WC;
        2: return WB;
        default: return WD;
      endcase
    end
    return ((i % 9) % 2 == 1) ? WB : WA;
  endfunction
  task automatic line(input int npix, input int pat, input logic m0, input logic m1);
    for (int k = 0; k < npix + 14; k++) begin
      hdmi_mode = (k == 0) ? m0 : m1;
      vde = k < npix;
      red = (k < npix && pat == 1 && k % 2 == 0) ? 8'hff : 8'h00;
      @(negedge clk);
      o0[k] = tmds_ch0;
      o1[k] = tmds_ch1;
      o2[k] = tmds_ch2;
      sb[k] = short_blank_err;
      step();
    end
    vde = 1'b0;
    red = '0;
  endtask
  task automatic chk_line(input string t, input int npix, input int pat, input logic ins, input int k0, input logic sb0);
    logic [9:0] e0, e1, e2;
    for (int k = k0; k < npix + 14; k++) begin
      if (k >= 12 && k < 12 + npix) {e0, e1, e2} = {dword(pat, 0, k - 12), dword(pat, 1, k - 12), dword(pat, 2, k - 12)};
      else if (ins && k >= 10 && k < 12) {e0, e1, e2} = {GB0, GB1, GB0};
      else if (ins && k >= 2 && k < 10) {e0, e1, e2} = {CTL0, CTL1, CTL0};
      else {e0, e1, e2} = {CTL0, CTL0, CTL0};
      chk($sformatf("%s ch0 k=%0d", t, k), o0[k], e0);
      chk($sformatf("%s ch1 k=%0d", t, k), o1[k], e1);
      chk($sformatf("%s ch2 k=%0d", t, k), o2[k], e2);
    end
    chk($sformatf("%s sbe edge", t), sb[0], sb0);
    chk($sformatf("%s sbe after", t), sb[1], 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ch0", tmds_ch0, CTL0);
    chk("reset ch1", tmds_ch1, CTL0);
    chk("reset ch2", tmds_ch2, CTL0);
    chk("reset sbe", short_blank_err, 0);
    chk("reset disp_err", disp_err, 0);
    step();
    rst = 1'b0;
    blank(20, 1'b0);
    line(1, 0, 1'b0, 1'b0);
    chk_line("dvi", 1, 0, 1'b0, 0, 1'b0);
    blank(20, 1'b1);
    line(1, 0, 1'b1, 1'b1);
    chk_line("hdmi", 1, 0, 1'b1, 0, 1'b0);
    blank(20, 1'b1);
    vde = 1'b1;
    repeat (3) step();
    vde = 1'b0;
    repeat (5) step();
    line(1, 0, 1'b1, 1'b1);
    chk_line("short", 1, 0, 1'b0, 7, 1'b1);
    blank(20, 1'b0);
    line(640, 1, 1'b0, 1'b0);
    chk_line("line640", 640, 1, 1'b0, 0, 1'b0);
    chk("line640 disp_err", disp_err, 0);
    blank(20, 1'b1);
    vde = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 4) chk("rst preamble ch1", tmds_ch1, CTL1);
      if (k >= 5) begin
        chk($sformatf("rst ch0 k=%0d", k), tmds_ch0, CTL0);
        chk($sformatf("rst ch1 k=%0d", k), tmds_ch1, CTL0);
        chk($sformatf("rst ch2 k=%0d", k), tmds_ch2, CTL0);
      end
      step();
      vde = 1'b0;
      rst = (k == 3);
    end
    blank(20, 1'b1);
    line(2, 0, 1'b1, 1'b0);
    chk_line("tog10", 2, 0, 1'b1, 0, 1'b0);
    blank(20, 1'b0);
    line(1, 0, 1'b0, 1'b1);
    chk_line("tog01", 1, 0, 1'b0, 0, 1'b0);
    blank(20, 1'b1);
    line(1, 0, 1'b1, 1'b1);
    chk_line("tog next", 1, 0, 1'b1, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
